// File: rtl/ccff_ctrl_pkg.sv
// Shared types and constants for the configuration-chain load controller.
// Holds the FSM state encoding and the default integrity preamble.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_LOAD = 2'd2,
    ST_FIN  = 2'd3
  } ccff_state_e;

  localparam logic [7:0] CCFF_PREAMBLE_DEFAULT = 8'hA5;
  localparam int         PRE_LEN               = 8;
  localparam int         WORD_W                = 8;

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word shifter plus one-word holding register turning bitstream bytes
// into a serial MSB-first bit stream for the configuration chain.
module ccff_word_serializer
  import ccff_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load_en,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  input  logic              pop,
  output logic              bit_avail,
  output logic              bit_out
);

  logic [WORD_W-1:0] sh_q;
  logic [WORD_W-1:0] hold_q;
  logic [3:0]        cnt_q;
  logic              hold_vld_q;
  logic              accept;
  logic              drain;

  // A word is taken only while the holding register is free, so at most
  // two words are ever buffered.
  assign bs_ready  = load_en && !hold_vld_q;
  assign accept    = bs_valid && bs_ready;
  assign bit_avail = (cnt_q != 4'd0);
  assign bit_out   = sh_q[WORD_W-1];

  // The shifter is empty now or becomes empty at this edge; refilling it
  // in the same edge is what avoids bubbles between words.
  assign drain = (cnt_q == 4'd0) || ((cnt_q == 4'd1) && pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sh_q       <= '0;
      hold_q     <= '0;
      cnt_q      <= 4'd0;
      hold_vld_q <= 1'b0;
    end else begin
      if (drain && hold_vld_q) begin
        sh_q       <= hold_q;
        cnt_q      <= 4'd8;
        hold_vld_q <= 1'b0;
      end else if (drain && accept) begin
        sh_q  <= bs_data;
        cnt_q <= 4'd8;
      end else if (pop) begin
        sh_q  <= {sh_q[WORD_W-2:0], 1'b0};
        cnt_q <= cnt_q - 4'd1;
      end

      if (accept && !drain) begin
        hold_q     <= bs_data;
        hold_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_load_ctrl.sv
// Configuration-chain load controller: shifts a preamble then CHAIN_LEN
// payload bits into the chain and checks the preamble emerging at the tail.
module ccff_load_ctrl
  import ccff_ctrl_pkg::*;
#(
  parameter int         CHAIN_LEN = 64,
  parameter logic [7:0] PREAMBLE  = CCFF_PREAMBLE_DEFAULT
) (
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] bs_data,
  input  logic       bs_valid,
  output logic       bs_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  localparam int CW    = $clog2(CHAIN_LEN + 1);
  localparam int WORDS = CHAIN_LEN / WORD_W;
  localparam int WW    = $clog2(WORDS + 1);

  ccff_state_e state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic          cfg_err_q, cfg_err_d;
  logic          head_q, head_d;
  logic          shift_en;
  logic          flush;
  logic          load_en;
  logic          pop;
  logic          bit_avail;
  logic          bit_out;
  logic          in_tail;
  logic [2:0]    pat_idx;

  ccff_word_serializer u_ser (
    .clk      (prog_clk),
    .rst      (pReset),
    .flush    (flush),
    .load_en  (load_en),
    .bs_data  (bs_data),
    .bs_valid (bs_valid),
    .bs_ready (bs_ready),
    .pop      (pop),
    .bit_avail(bit_avail),
    .bit_out  (bit_out)
  );

  // CHAIN_LEN is a multiple of 8, so the low three counter bits select the
  // preamble bit both while sending it and while checking it at the tail.
  assign pat_idx = ~bit_cnt_q[2:0];
  assign in_tail = (bit_cnt_q >= CW'(CHAIN_LEN - PRE_LEN));
  assign pop     = (state_q == ST_LOAD) && bit_avail;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
      head_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      cfg_err_q  <= cfg_err_d;
      head_q     <= head_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    cfg_err_d  = cfg_err_q;
    head_d     = head_q;
    shift_en   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    flush      = 1'b0;
    load_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PRE;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          cfg_err_d  = 1'b0;
          flush      = 1'b1;
        end
      end

      ST_PRE: begin
        busy     = 1'b1;
        load_en  = (word_cnt_q < WW'(WORDS));
        shift_en = 1'b1;
        head_d   = PREAMBLE[pat_idx];
        if (bit_cnt_q == CW'(PRE_LEN - 1)) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      ST_LOAD: begin
        busy    = 1'b1;
        load_en = (word_cnt_q < WW'(WORDS));
        if (bit_avail) begin
          shift_en  = 1'b1;
          head_d    = bit_out;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (in_tail && (ccff_tail != PREAMBLE[pat_idx])) begin
            cfg_err_d = 1'b1;
          end
          if (bit_cnt_q == CW'(CHAIN_LEN - 1)) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (busy && bs_valid && bs_ready) begin
      word_cnt_d = word_cnt_q + WW'(1);
    end

    // Abort takes effect at this edge; the current cycle completes normally.
    if (busy && abort) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      cfg_err_d  = 1'b1;
      flush      = 1'b1;
    end
  end

  // During a stall head_d keeps head_q, so the head bit stays put.
  assign ccff_head     = head_d;
  assign ccff_shift_en = shift_en;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// Bench for ccff_load_ctrl with a 16-bit chain model (optionally 17 bits)
// clocked by ccff_shift_en; directed scenarios with hand-derived results.
module tb_ccff_load_ctrl;

  logic       prog_clk;
  logic       pReset;
  logic       start;
  logic       abort;
  logic [7:0] bs_data;
  logic       bs_valid;
  logic       bs_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int checks = 0;
  int passes = 0;

  // chain model and observation counters
  logic [16:0] chain_q = '0;
  bit          extra_flop = 1'b0;
  int          cyc = 0;
  int          shift_cnt = 0;
  int          stall_cnt = 0;
  int          head_err = 0;
  int          done_cnt = 0;
  int          first_cyc = -1;
  int          last_cyc = -1;
  logic [7:0]  pre_bits = '0;
  logic        last_head = 1'b0;
  logic        err_at_done = 1'b0;

  ccff_load_ctrl #(.CHAIN_LEN(16), .PREAMBLE(8'hA5)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .abort        (abort),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  // clock / reset block
  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  assign ccff_tail = extra_flop ? chain_q[16] : chain_q[15];

  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain_q <= {chain_q[15:0], ccff_head};
  end

  always @(negedge prog_clk) begin
    cyc++;
    if (ccff_shift_en) begin
      if (shift_cnt < 8) pre_bits = {pre_bits[6:0], ccff_head};
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc  = cyc;
      last_head = ccff_head;
      shift_cnt++;
    end else if (busy) begin
      stall_cnt++;
      if (ccff_head !== last_head) head_err++;
    end
    if (done) begin
      done_cnt++;
      err_at_done = cfg_err;
    end
  end

  // Runs one load: word 0 = 3C, word 1 = F0. gap>0 holds word 1 back until
  // word 0 drains and then for gap more cycles. *_at fire at a shift count.
  task automatic drive_load(input int gap, input int abort_at, input int reset_at,
                            input int start_at, output bit hit);
    int  w;
    int  gap_left;
    bit  armed;
    hit = 1'b0; w = 0; gap_left = 0; armed = 1'b0;
    @(negedge prog_clk); #1;
    shift_cnt = 0; stall_cnt = 0; head_err = 0; done_cnt = 0;
    first_cyc = -1; last_cyc = -1; pre_bits = '0; err_at_done = 1'b0;
    start = 1'b1; bs_valid = 1'b0;
    @(negedge prog_clk); #1;
    start = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (c > 0) begin
        @(negedge prog_clk); #1;
      end
      if (done_cnt > 0) begin
        hit = 1'b1;
        break;
      end
      start = (start_at >= 0) && (shift_cnt == start_at);
      if (w == 0) begin
        bs_valid = 1'b1; bs_data = 8'h3C;
      end else if (w == 1 && gap == 0) begin
        bs_valid = 1'b1; bs_data = 8'hF0;
      end else if (w == 1 && !armed) begin
        bs_valid = 1'b0;
        if (shift_cnt >= 16) begin
          armed = 1'b1; gap_left = gap;
        end
      end else if (w == 1 && gap_left > 1) begin
        bs_valid = 1'b0; gap_left--;
      end else if (w == 1) begin
        bs_valid = 1'b1; bs_data = 8'hF0;
      end else begin
        bs_valid = 1'b0;
      end
      if (abort_at >= 0 && shift_cnt == abort_at) abort = 1'b1;
      if (reset_at >= 0 && shift_cnt == reset_at) pReset = 1'b1;
      #1;
      if (bs_valid && bs_ready) w++;
      if (abort || pReset) begin
        @(negedge prog_clk); #1;
        abort = 1'b0; pReset = 1'b0; bs_valid = 1'b0; start = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    bs_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b1; start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
    repeat (3) @(negedge prog_clk);
    #1 pReset = 1'b0;
    #1;
    checks++; if (bs_ready !== 1'b0) $display("FAIL rst_bs_ready got %b want 0", bs_ready); else passes++;
    checks++; if (ccff_head !== 1'b0) $display("FAIL rst_head got %b want 0", ccff_head); else passes++;
    checks++; if (ccff_shift_en !== 1'b0) $display("FAIL rst_shift_en got %b want 0", ccff_shift_en); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passes++;
    checks++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err got %b want 0", cfg_err); else passes++;
  endtask

  task automatic test_back_to_back();
    bit hit;
    drive_load(0, -1, -1, -1, hit);
    repeat (2) @(negedge prog_clk);
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL v1_timeout got %b want 1", hit); else passes++;
    checks++; if (shift_cnt !== 24) $display("FAIL v1_shifts got %0d want 24", shift_cnt); else passes++;
    checks++; if (last_cyc - first_cyc + 1 !== 24) $display("FAIL v1_span got %0d want 24", last_cyc - first_cyc + 1); else passes++;
    checks++; if (pre_bits !== 8'hA5) $display("FAIL v1_preamble got %h want a5", pre_bits); else passes++;
    checks++; if (chain_q[15:0] !== 16'h3CF0) $display("FAIL v1_chain got %h want 3cf0", chain_q[15:0]); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL v1_done_cnt got %0d want 1", done_cnt); else passes++;
    checks++; if (err_at_done !== 1'b0) $display("FAIL v1_cfg_err got %b want 0", err_at_done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL v1_busy_after got %b want 0", busy); else passes++;
  endtask

  task automatic test_stall();
    bit hit;
    drive_load(5, -1, -1, -1, hit);
    repeat (2) @(negedge prog_clk);
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL v2_timeout got %b want 1", hit); else passes++;
    checks++; if (shift_cnt !== 24) $display("FAIL v2_shifts got %0d want 24", shift_cnt); else passes++;
    checks++; if (stall_cnt !== 5) $display("FAIL v2_stalls got %0d want 5", stall_cnt); else passes++;
    checks++; if (last_cyc - first_cyc + 1 !== 29) $display("FAIL v2_span got %0d want 29", last_cyc - first_cyc + 1); else passes++;
    checks++; if (head_err !== 0) $display("FAIL v2_head_moved got %0d want 0", head_err); else passes++;
    checks++; if (chain_q[15:0] !== 16'h3CF0) $display("FAIL v2_chain got %h want 3cf0", chain_q[15:0]); else passes++;
    checks++; if (err_at_done !== 1'b0) $display("FAIL v2_cfg_err got %b want 0", err_at_done); else passes++;
  endtask

  task automatic test_long_chain();
    bit hit;
    extra_flop = 1'b1;
    drive_load(0, -1, -1, -1, hit);
    repeat (2) @(negedge prog_clk);
    #1;
    extra_flop = 1'b0;
    checks++; if (hit !== 1'b1) $display("FAIL v3_timeout got %b want 1", hit); else passes++;
    checks++; if (err_at_done !== 1'b1) $display("FAIL v3_cfg_err got %b want 1", err_at_done); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL v3_done_cnt got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_abort();
    bit hit;
    drive_load(0, 10, -1, -1, hit);
    checks++; if (hit !== 1'b1) $display("FAIL v4_timeout got %b want 1", hit); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL v4_busy got %b want 0", busy); else passes++;
    checks++; if (ccff_shift_en !== 1'b0) $display("FAIL v4_shift_en got %b want 0", ccff_shift_en); else passes++;
    checks++; if (bs_ready !== 1'b0) $display("FAIL v4_bs_ready got %b want 0", bs_ready); else passes++;
    checks++; if (cfg_err !== 1'b1) $display("FAIL v4_cfg_err got %b want 1", cfg_err); else passes++;
    repeat (4) @(negedge prog_clk);
    #1;
    checks++; if (done_cnt !== 0) $display("FAIL v4_done_cnt got %0d want 0", done_cnt); else passes++;
    checks++; if (shift_cnt !== 10) $display("FAIL v4_shifts got %0d want 10", shift_cnt); else passes++;
  endtask

  task automatic test_reset_mid_load();
    bit hit;
    drive_load(0, -1, 12, -1, hit);
    checks++; if (hit !== 1'b1) $display("FAIL v5_timeout got %b want 1", hit); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL v5_busy got %b want 0", busy); else passes++;
    checks++; if (ccff_shift_en !== 1'b0) $display("FAIL v5_shift_en got %b want 0", ccff_shift_en); else passes++;
    checks++; if (bs_ready !== 1'b0) $display("FAIL v5_bs_ready got %b want 0", bs_ready); else passes++;
    checks++; if (ccff_head !== 1'b0) $display("FAIL v5_head got %b want 0", ccff_head); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL v5_done got %b want 0", done); else passes++;
    checks++; if (cfg_err !== 1'b0) $display("FAIL v5_cfg_err got %b want 0", cfg_err); else passes++;
    drive_load(0, -1, -1, -1, hit);
    repeat (2) @(negedge prog_clk);
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL v5_reload_timeout got %b want 1", hit); else passes++;
    checks++; if (chain_q[15:0] !== 16'h3CF0) $display("FAIL v5_reload_chain got %h want 3cf0", chain_q[15:0]); else passes++;
    checks++; if (err_at_done !== 1'b0) $display("FAIL v5_reload_cfg_err got %b want 0", err_at_done); else passes++;
  endtask

  task automatic test_start_during_load();
    bit hit;
    drive_load(0, -1, -1, 12, hit);
    repeat (3) @(negedge prog_clk);
    #1;
    checks++; if (hit !== 1'b1) $display("FAIL v6_timeout got %b want 1", hit); else passes++;
    checks++; if (shift_cnt !== 24) $display("FAIL v6_shifts got %0d want 24", shift_cnt); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL v6_done_cnt got %0d want 1", done_cnt); else passes++;
    checks++; if (chain_q[15:0] !== 16'h3CF0) $display("FAIL v6_chain got %h want 3cf0", chain_q[15:0]); else passes++;
    checks++; if (err_at_done !== 1'b0) $display("FAIL v6_cfg_err got %b want 0", err_at_done); else passes++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_long_chain();
    test_abort();
    test_reset_mid_load();
    test_start_during_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
